// File: rtl/dp_decode_issue.sv
// Decode/issue front end for the A32 data-processing op units: decodes one word, checks the
// condition, reads operands, strobes the op unit, captures its result and writes Rd back.
module dp_decode_issue #(
  parameter logic [3:0] OPCODE = 4'b0001,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [3:0]        rf_raddr_n,
  output logic [3:0]        rf_raddr_m,
  input  logic [DATA_W-1:0] rf_rdata_n,
  input  logic [DATA_W-1:0] rf_rdata_m,
  output logic              op_en_inst,
  output logic              op_imm,
  output logic              op_s,
  output logic [DATA_W-1:0] op_rn,
  output logic [DATA_W-1:0] op_rm,
  output logic [11:0]       op_imm_operand,
  output logic [4:0]        op_imm_shift,
  output logic [1:0]        op_stype,
  output logic              op_carry_in,
  output logic              op_zero_in,
  output logic              op_neg_in,
  input  logic [DATA_W-1:0] op_rd,
  input  logic              op_carry_out,
  input  logic              op_zero_out,
  input  logic              op_neg_out,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_CAPTURE,
    S_WB
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] rn_q;
  logic [DATA_W-1:0] rm_q;
  logic [DATA_W-1:0] res_q;
  logic              cap_n;
  logic              cap_z;
  logic              cap_c;
  logic              cond_legal;
  logic              cond_pass;
  logic              reject;

  // Only EQ/NE/CS/CC/MI/PL/AL are supported; any other condition code is rejected.
  always_comb begin
    cond_legal = 1'b1;
    cond_pass  = 1'b0;
    case (instr_q[31:28])
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b1110: cond_pass = 1'b1;
      default: cond_legal = 1'b0;
    endcase
  end

  assign reject = (instr_q[27:26] != 2'b00)
                | (instr_q[24:21] != OPCODE)
                | (~instr_q[25] & instr_q[4])
                | (instr_q[15:12] == 4'hF)
                | ~cond_legal;

  // Field outputs come straight from the latched word, so they stay put until the next accept.
  assign op_imm         = instr_q[25];
  assign op_s           = instr_q[20];
  assign op_imm_operand = instr_q[11:0];
  assign op_imm_shift   = instr_q[11:7];
  assign op_stype       = instr_q[6:5];
  assign op_rn          = rn_q;
  assign op_rm          = rm_q;
  assign op_carry_in    = flag_c;
  assign op_zero_in     = flag_z;
  assign op_neg_in      = flag_n;

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    rf_raddr_n  = 4'd0;
    rf_raddr_m  = 4'd0;
    op_en_inst  = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = 4'd0;
    rf_wdata    = '0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = S_DECODE;
      end
      S_DECODE: begin
        rf_raddr_n = instr_q[19:16];
        rf_raddr_m = instr_q[3:0];
        if (reject) begin
          done       = 1'b1;
          err        = 1'b1;
          state_next = S_IDLE;
        end else if (!cond_pass) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        op_en_inst = 1'b1;
        state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        op_en_inst = 1'b1;
        state_next = S_WB;
      end
      S_WB: begin
        rf_we      = 1'b1;
        rf_waddr   = instr_q[15:12];
        rf_wdata   = res_q;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operands are latched in DECODE so Rn==Rd or Rm==Rd still sees the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      instr_q <= 32'd0;
      rn_q    <= '0;
      rm_q    <= '0;
      res_q   <= '0;
      cap_n   <= 1'b0;
      cap_z   <= 1'b0;
      cap_c   <= 1'b0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && instr_valid) instr_q <= instr;
      if (state == S_DECODE) begin
        rn_q <= rf_rdata_n;
        rm_q <= rf_rdata_m;
      end
      if (state == S_CAPTURE) begin
        res_q <= op_rd;
        cap_n <= op_neg_out;
        cap_z <= op_zero_out;
        cap_c <= op_carry_out;
      end
      if (state == S_WB && instr_q[20]) begin
        flag_n <= cap_n;
        flag_z <= cap_z;
        flag_c <= cap_c;
      end
    end
  end

endmodule
